bi_dir_piso_serializer: RTL and testbench

- Parallel-in, serial-out shift register with a selectable shift direction. It is the transmit-side counterpart of the serial-in, parallel-out bidirectional shift register.
- Accepts a WIDTH-bit word through a valid/ready load handshake. Emits the word one bit per shift_en tick, MSB-first or LSB-first. Pulses done when the last bit has been emitted.
- Sits between a parallel word source and a serial link. shift_en is the bit-rate tick.

---
 rtl/bi_dir_piso_serializer_if.sv | 40 ++++
 rtl/bi_dir_piso_serializer.sv | 90 +++++++++
 tb/tb_bi_dir_piso_serializer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/bi_dir_piso_serializer_if.sv
// Load handshake and serial-side signals of the bidirectional PISO serializer.
interface bi_dir_piso_serializer_if #(
    parameter int unsigned WIDTH = 4
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] data_in;
    logic             shift_left;
    logic             shift_en;
    logic             serial_out;
    logic             serial_valid;
    logic             busy;
    logic             done;

    // Word source / link controller side
    modport master (
        output load_valid,
        output data_in,
        output shift_left,
        output shift_en,
        input  load_ready,
        input  serial_out,
        input  serial_valid,
        input  busy,
        input  done
    );

    // Serializer side
    modport slave (
        input  load_valid,
        input  data_in,
        input  shift_left,
        input  shift_en,
        output load_ready,
        output serial_out,
        output serial_valid,
        output busy,
        output done
    );
endinterface

// File: rtl/bi_dir_piso_serializer.sv
// Parallel-in, serial-out shift register with per-word selectable direction.
// A word is accepted via load_valid/load_ready, then emitted one bit per shift_en tick.
// All outputs are decoded from registers only.
module bi_dir_piso_serializer #(
    parameter int unsigned WIDTH = 4,
    parameter logic        FILL  = 1'b0
) (
    input logic                    clk,
    input logic                    rst,
    bi_dir_piso_serializer_if.slave bus
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    typedef enum logic {StIdle, StShift} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             dir_q, dir_d;
    logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
    logic             done_q, done_d;

    // State register; synchronous reset discards any word in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            shreg_q   <= '0;
            dir_q     <= 1'b0;
            bit_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            dir_q     <= dir_d;
            bit_cnt_q <= bit_cnt_d;
            done_q    <= done_d;
        end
    end

    // Next-state: load in idle, shift/count on ticks, end with a one-cycle done
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        dir_d     = dir_q;
        bit_cnt_d = bit_cnt_q;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.load_valid) begin
                    shreg_d   = bus.data_in;
                    dir_d     = bus.shift_left;
                    bit_cnt_d = '0;
                    state_d   = StShift;
                end
            end
            StShift: begin
                if (bus.shift_en) begin
                    if (bit_cnt_q == LastBit) begin
                        // Last bit consumed; shreg content is irrelevant once idle
                        state_d   = StIdle;
                        done_d    = 1'b1;
                        bit_cnt_d = '0;
                    end else begin
                        if (dir_q) begin
                            shreg_d = {shreg_q[WIDTH-2:0], FILL};
                        end else begin
                            shreg_d = {FILL, shreg_q[WIDTH-1:1]};
                        end
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output decode from registered state only
    always_comb begin
        bus.load_ready   = (state_q == StIdle);
        bus.busy         = (state_q == StShift);
        bus.serial_valid = (state_q == StShift);
        bus.done         = done_q;
        bus.serial_out   = 1'b0;
        if (state_q == StShift) begin
            bus.serial_out = dir_q ? shreg_q[WIDTH-1] : shreg_q[0];
        end
    end

endmodule

// File: tb/tb_bi_dir_piso_serializer.sv
// Self-checking bench for bi_dir_piso_serializer (WIDTH=4): vector table,
// directed multi-cycle sequences, and randomized traffic against a queue model.
module tb_bi_dir_piso_serializer;

    localparam int unsigned W = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    bi_dir_piso_serializer_if #(.WIDTH(W)) bus ();

    bi_dir_piso_serializer #(
        .WIDTH(W),
        .FILL (1'b0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Output vector order: {serial_out, serial_valid, busy, done, load_ready}
    typedef struct {
        logic         rst;
        logic         lv;
        logic [W-1:0] d;
        logic         sl;
        logic         se;
        logic [4:0]   exp;
    } vec_t;

    vec_t vecs[13];

    logic         q_bits[$];
    logic         m_busy;
    logic         m_done;

    function automatic logic [4:0] outs();
        return {bus.serial_out, bus.serial_valid, bus.busy, bus.done, bus.load_ready};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic lv, input logic [W-1:0] d,
                         input logic sl, input logic se);
        rst            = r;
        bus.load_valid = lv;
        bus.data_in    = d;
        bus.shift_left = sl;
        bus.shift_en   = se;
    endtask

    // Reference model: a word becomes a queue of bits in emission order
    task automatic model_edge(input logic r, input logic lv, input logic [W-1:0] d,
                              input logic sl, input logic se);
        if (r) begin
            q_bits.delete();
            m_busy = 1'b0;
            m_done = 1'b0;
        end else if (!m_busy) begin
            m_done = 1'b0;
            if (lv) begin
                for (int i = 0; i < int'(W); i++) begin
                    q_bits.push_back(sl ? d[W-1-i] : d[i]);
                end
                m_busy = 1'b1;
            end
        end else begin
            m_done = 1'b0;
            if (se) begin
                void'(q_bits.pop_front());
                if (q_bits.size() == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end
        end
    endtask

    function automatic logic [4:0] model_outs();
        logic so;
        so = m_busy ? q_bits[0] : 1'b0;
        return {so, m_busy, m_busy, m_done, !m_busy};
    endfunction

    function automatic vec_t mk(input logic r, input logic lv, input logic [W-1:0] d,
                                input logic sl, input logic se, input logic [4:0] e);
        vec_t v;
        v.rst = r; v.lv = lv; v.d = d; v.sl = sl; v.se = se; v.exp = e;
        return v;
    endfunction

    initial begin
        logic [3:0] exp_bits;
        int         busy_cycles;
        logic       saw_done;

        // Expected values: MSB-first 1011 -> 1,0,1,1; LSB-first 1011 -> 1,1,0,1
        vecs[0]  = mk(1, 0, 4'h0,    0, 0, 5'b00001);
        vecs[1]  = mk(0, 1, 4'b1011, 1, 1, 5'b11100);
        vecs[2]  = mk(0, 0, 4'h0,    0, 1, 5'b01100);
        vecs[3]  = mk(0, 0, 4'h0,    0, 1, 5'b11100);
        vecs[4]  = mk(0, 0, 4'h0,    0, 1, 5'b11100);
        vecs[5]  = mk(0, 0, 4'h0,    0, 1, 5'b00011);
        vecs[6]  = mk(0, 0, 4'h0,    0, 1, 5'b00001);
        vecs[7]  = mk(0, 1, 4'b1011, 0, 1, 5'b11100);
        vecs[8]  = mk(0, 0, 4'h0,    1, 1, 5'b11100);
        vecs[9]  = mk(0, 0, 4'h0,    1, 1, 5'b01100);
        vecs[10] = mk(0, 0, 4'h0,    1, 1, 5'b11100);
        vecs[11] = mk(0, 0, 4'h0,    1, 1, 5'b00011);
        vecs[12] = mk(0, 0, 4'h0,    1, 0, 5'b00001);

        drive(1, 0, '0, 0, 0);
        step();

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].rst, vecs[i].lv, vecs[i].d, vecs[i].sl, vecs[i].se);
            step();
            check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
        end

        // Bits stretched by shift_en every third cycle: 0110 MSB-first
        exp_bits    = 4'b0110;
        busy_cycles = 0;
        drive(0, 1, 4'b0110, 1, 0);
        step();
        drive(0, 0, '0, 1, 0);
        for (int k = 0; k < 12; k++) begin
            check($sformatf("slow_bit%0d", k), 32'(bus.serial_out), 32'(exp_bits[3 - k/3]));
            if (k == 11) check("slow_no_early_done", 32'(bus.done), 32'd0);
            if (bus.busy) busy_cycles++;
            bus.shift_en = (k % 3 == 2);
            step();
        end
        check("slow_busy_cycles", 32'(busy_cycles), 32'd12);
        check("slow_done", 32'(outs()), 32'b00011);
        bus.shift_en = 1'b0;
        step();
        check("slow_done_one_cycle", 32'(bus.done), 32'd0);

        // Back-to-back words with load_valid held high
        drive(0, 1, 4'b1000, 1, 1);
        step();
        bus.data_in = 4'b0001;
        exp_bits    = 4'b1000;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("b2b_a_bit%0d", k), 32'(outs()), 32'({exp_bits[3-k], 4'b1100}));
            step();
        end
        check("b2b_done_cycle", 32'(outs()), 32'b00011);
        step();
        exp_bits = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("b2b_b_bit%0d", k), 32'(outs()), 32'({exp_bits[3-k], 4'b1100}));
            bus.load_valid = (k < 3);
            step();
        end
        check("b2b_b_done", 32'(outs()), 32'b00011);

        // Reset mid-word discards it without done
        drive(0, 1, 4'b1111, 1, 1);
        step();
        drive(0, 0, '0, 1, 1);
        step();
        drive(1, 0, '0, 1, 1);
        step();
        check("rst_mid_outs", 32'(outs()), 32'b00001);
        drive(0, 0, '0, 1, 1);
        saw_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (bus.done) saw_done = 1'b1;
        end
        check("rst_mid_no_done", 32'(saw_done), 32'd0);
        drive(0, 1, 4'b0101, 1, 1);
        step();
        bus.load_valid = 1'b0;
        exp_bits = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rst_reload_bit%0d", k), 32'(bus.serial_out), 32'(exp_bits[3-k]));
            step();
        end
        check("rst_reload_done", 32'(bus.done), 32'd1);

        // shift_left toggled mid-word must not change direction
        drive(0, 1, 4'b1100, 0, 1);
        step();
        bus.load_valid = 1'b0;
        exp_bits = 4'b1100;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("flip_bit%0d", k), 32'(bus.serial_out), 32'(exp_bits[k]));
            bus.shift_left = ~bus.shift_left;
            step();
        end
        check("flip_done", 32'(bus.done), 32'd1);

        // Randomized traffic against the queue model
        drive(1, 0, '0, 0, 0);
        model_edge(1, 0, '0, 0, 0);
        step();
        check("rand_reset", 32'(outs()), 32'(model_outs()));
        for (int c = 0; c < 3000; c++) begin
            logic         r, lv, sl, se;
            logic [W-1:0] d;
            r  = ($urandom_range(0, 63) == 0);
            lv = ($urandom_range(0, 2) != 0);
            sl = 1'($urandom);
            se = ($urandom_range(0, 4) < 3);
            d  = W'($urandom);
            drive(r, lv, d, sl, se);
            model_edge(r, lv, d, sl, se);
            step();
            check($sformatf("rand_c%0d", c), 32'(outs()), 32'(model_outs()));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
